// File: rtl/gate_drive_guard.sv
// Last stage before the H-bridge gate drivers. It enforces the per-leg interlock, dead time and
// minimum pulse width, and turns every gate off on filtered, latched OCP/OVP/E-stop faults.
`timescale 1ns/1ps
module gate_drive_guard #(
    parameter int NUM_LEGS   = 4,
    parameter int DT_CYCLES  = 50,
    parameter int MIN_PULSE  = 25,
    parameter int FLT_FILTER = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NUM_LEGS-1:0] pwm_in,
    input  logic                  enable,
    input  logic                  fault_ocp,
    input  logic                  fault_ovp,
    input  logic                  estop_n,
    input  logic                  fault_clear,
    output logic [2*NUM_LEGS-1:0] gate_out,
    output logic                  fault_latched,
    output logic [2:0]            fault_cause,
    output logic [NUM_LEGS-1:0]   shoot_through_err
);

    localparam int CNT_W = (DT_CYCLES > 1) ? $clog2(DT_CYCLES) : 1;
    localparam int ON_W  = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
    localparam int FLT_W = $clog2(FLT_FILTER + 1);

    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_CYCLES - 1);
    localparam logic [ON_W-1:0]  ON_LOAD = ON_W'(MIN_PULSE - 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FLT_FILTER);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_DEAD = 4'b0010,
        ST_HIGH = 4'b0100,
        ST_LOW  = 4'b1000
    } leg_state_t;

    genvar gi;

    // Fault inputs, bit order {estop, ovp, ocp}; estop is inverted so every bit is active-high.
    logic [2:0] fault_raw;
    logic [2:0] flt_active;

    assign fault_raw = {~estop_n, fault_ovp, fault_ocp};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_flt
            logic             sync1_reg;
            logic             sync2_reg;
            logic [FLT_W-1:0] cnt_reg;
            logic [FLT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (!sync2_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg != FLT_MAX) begin
                    cnt_next = cnt_reg + FLT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= fault_raw[gi];
                    sync2_reg <= sync1_reg;
                    cnt_reg   <= cnt_next;
                end
            end

            assign flt_active[gi] = (cnt_reg == FLT_MAX);
        end
    endgenerate

    // Fault latch and sticky status
    logic                any_flt;
    logic                clear_ok;
    logic                force_off;
    logic                fault_latched_reg;
    logic                fault_latched_next;
    logic [2:0]          fault_cause_reg;
    logic [2:0]          fault_cause_next;
    logic [NUM_LEGS-1:0] st_err_reg;
    logic [NUM_LEGS-1:0] st_err_next;
    logic [NUM_LEGS-1:0] st_req;

    assign any_flt   = |flt_active;
    // A fault that is active in the same cycle as fault_clear always wins.
    assign clear_ok  = fault_clear & ~any_flt;
    assign force_off = ~enable | fault_latched_reg | any_flt;

    always_comb begin
        fault_latched_next = (fault_latched_reg & ~clear_ok) | any_flt;
        fault_cause_next   = (clear_ok ? 3'b000 : fault_cause_reg) | flt_active;
        st_err_next        = (clear_ok ? '0 : st_err_reg) | st_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched_reg <= 1'b0;
            fault_cause_reg   <= 3'b000;
            st_err_reg        <= '0;
        end else begin
            fault_latched_reg <= fault_latched_next;
            fault_cause_reg   <= fault_cause_next;
            st_err_reg        <= st_err_next;
        end
    end

    assign fault_latched     = fault_latched_reg;
    assign fault_cause       = fault_cause_reg;
    assign shoot_through_err = st_err_reg;

    // Per-leg interlock FSM
    generate
        for (gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
            logic            req_hi;
            logic            req_lo;
            leg_state_t      state_reg;
            leg_state_t      state_next;
            logic [CNT_W-1:0] dt_cnt_reg;
            logic [CNT_W-1:0] dt_cnt_next;
            logic [ON_W-1:0]  on_cnt_reg;
            logic [ON_W-1:0]  on_cnt_next;

            assign req_hi     =  pwm_in[2*gi] & ~pwm_in[2*gi+1];
            assign req_lo     = ~pwm_in[2*gi] &  pwm_in[2*gi+1];
            assign st_req[gi] =  pwm_in[2*gi] &  pwm_in[2*gi+1];

            always_comb begin
                state_next  = state_reg;
                dt_cnt_next = dt_cnt_reg;
                on_cnt_next = on_cnt_reg;
                if (force_off) begin
                    state_next  = ST_IDLE;
                    dt_cnt_next = '0;
                    on_cnt_next = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (req_hi || req_lo) begin
                                state_next  = ST_DEAD;
                                dt_cnt_next = DT_LOAD;
                            end
                        end
                        ST_DEAD: begin
                            if (dt_cnt_reg != '0) begin
                                dt_cnt_next = dt_cnt_reg - CNT_W'(1);
                            end else if (req_hi) begin
                                state_next  = ST_HIGH;
                                on_cnt_next = ON_LOAD;
                            end else if (req_lo) begin
                                state_next  = ST_LOW;
                                on_cnt_next = ON_LOAD;
                            end else begin
                                state_next  = ST_IDLE;
                            end
                        end
                        ST_HIGH: begin
                            if (on_cnt_reg != '0) begin
                                on_cnt_next = on_cnt_reg - ON_W'(1);
                            end else if (!req_hi) begin
                                state_next  = ST_DEAD;
                                dt_cnt_next = DT_LOAD;
                            end
                        end
                        ST_LOW: begin
                            if (on_cnt_reg != '0) begin
                                on_cnt_next = on_cnt_reg - ON_W'(1);
                            end else if (!req_lo) begin
                                state_next  = ST_DEAD;
                                dt_cnt_next = DT_LOAD;
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg  <= ST_IDLE;
                    dt_cnt_reg <= '0;
                    on_cnt_reg <= '0;
                end else begin
                    state_reg  <= state_next;
                    dt_cnt_reg <= dt_cnt_next;
                    on_cnt_reg <= on_cnt_next;
                end
            end

            // Gates come straight from the one-hot state bits so the pins stay glitch-free.
            assign gate_out[2*gi]   = state_reg[2];
            assign gate_out[2*gi+1] = state_reg[3];
        end
    endgenerate

endmodule
